// File: rtl/wb_pkg.sv
// Shared types and default geometry for the write-back queue.
// Entry widths here fix the queue's DW/AW parameters.
package wb_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_DW    = 8;
  localparam int WB_AW    = 2;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-first forwarding search over the pending entries of the write-back queue.
// Only valid slots (head .. head+count-1) take part; a later match overrides an earlier one.
module wb_fwd_lookup
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  wb_entry_t          entries [DEPTH],
  input  logic [PW-1:0]      head,
  input  logic [PW:0]        count,
  input  logic [WB_AW-1:0]   lookup_addr,
  output logic               hit,
  output logic [WB_DW-1:0]   data
);

  logic [PW-1:0] idx;

  // NOTE: every always_comb output gets a default before any branch, otherwise a
  // path that skips the assignment infers a latch; blocking '=' is right here
  // because later loop iterations must see earlier results.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (entries[idx].addr == lookup_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: two producers in (load older than ALU), one register-file write out per cycle.
// Optional forwarding lookup enabled by defining WB_FWD_EN.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    LdValid,
  input  logic [AW-1:0]           LdAddr,
  input  logic [DW-1:0]           LdData,
  output logic                    LdReady,
  input  logic                    AluValid,
  input  logic [AW-1:0]           AluAddr,
  input  logic [DW-1:0]           AluData,
  output logic                    AluReady,
  output logic                    Wen,
  output logic [AW-1:0]           Wd,
  output logic [DW-1:0]           Wdat,
  output logic [$clog2(DEPTH):0]  Level,
  input  logic [AW-1:0]           LookupAddr,
  output logic                    LookupHit,
  output logic [DW-1:0]           LookupData
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic [PW:0]   free;
  logic          ld_acc;
  logic          alu_acc;
  logic          pop;
  logic [PW-1:0] alu_slot;

  // Space comes from the registered count only; this cycle's pop frees nothing yet.
  assign free     = (PW+1)'(DEPTH) - count;
  assign LdReady  = !Reset && (free != '0);
  assign AluReady = !Reset && (LdValid ? (free >= (PW+1)'(2)) : (free != '0));

  assign ld_acc   = LdValid  && LdReady;
  assign alu_acc  = AluValid && AluReady;
  assign pop      = !Reset && (count != '0);
  assign alu_slot = ld_acc ? tail + PW'(1) : tail;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(ld_acc) + PW'(alu_acc);
      count <= count + (PW+1)'(ld_acc) + (PW+1)'(alu_acc) - (PW+1)'(pop);
    end
  end

  // NOTE: the entry storage is deliberately not reset; count gates every read,
  // so stale contents are never observable and the array stays plain RAM.
  always_ff @(posedge Clk) begin
    if (ld_acc) begin
      mem[tail].addr <= LdAddr;
      mem[tail].data <= LdData;
    end
    if (alu_acc) begin
      mem[alu_slot].addr <= AluAddr;
      mem[alu_slot].data <= AluData;
    end
  end

  // Retire port: the bus is forced to zero whenever no write is issued.
  always_comb begin
    Wen  = pop;
    Wd   = '0;
    Wdat = '0;
    if (pop) begin
      Wd   = mem[head].addr;
      Wdat = mem[head].data;
    end
  end

  assign Level = Reset ? '0 : count;

`ifdef WB_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  wb_fwd_lookup #(
    .DEPTH (DEPTH)
  ) u_fwd_lookup (
    .entries     (mem),
    .head        (head),
    .count       (count),
    .lookup_addr (LookupAddr),
    .hit         (fwd_hit),
    .data        (fwd_data)
  );

  assign LookupHit  = !Reset && fwd_hit;
  assign LookupData = LookupHit ? fwd_data : '0;
`else
  logic unused_lookup;
  assign unused_lookup = ^LookupAddr;
  assign LookupHit     = 1'b0;
  assign LookupData    = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_wb_queue;

  logic       Clk;
  logic       Reset;
  logic       LdValid;
  logic [1:0] LdAddr;
  logic [7:0] LdData;
  logic       LdReady;
  logic       AluValid;
  logic [1:0] AluAddr;
  logic [7:0] AluData;
  logic       AluReady;
  logic       Wen;
  logic [1:0] Wd;
  logic [7:0] Wdat;
  logic [2:0] Level;
  logic [1:0] LookupAddr;
  logic       LookupHit;
  logic [7:0] LookupData;

  wb_queue dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .LdValid    (LdValid),
    .LdAddr     (LdAddr),
    .LdData     (LdData),
    .LdReady    (LdReady),
    .AluValid   (AluValid),
    .AluAddr    (AluAddr),
    .AluData    (AluData),
    .AluReady   (AluReady),
    .Wen        (Wen),
    .Wd         (Wd),
    .Wdat       (Wdat),
    .Level      (Level),
    .LookupAddr (LookupAddr),
    .LookupHit  (LookupHit),
    .LookupData (LookupData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } ent_t;

  localparam int DEPTH = 4;

  ent_t       q[$];
  logic [7:0] rf     [4];
  logic [7:0] dut_rf [4];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  logic       obs_wen, obs_lready, obs_aready, obs_hit;
  logic [1:0] obs_wd;
  logic [7:0] obs_wdat, obs_ldata;
  logic [2:0] obs_level;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, update the model at the rising edge.
  task automatic step(input logic rst, input logic lv, input logic [1:0] la, input logic [7:0] ldd,
                      input logic av, input logic [1:0] aa, input logic [7:0] ad, input logic [1:0] lk);
    int n, fr;
    logic e_lr, e_ar, e_wen, e_hit;
    logic [1:0] e_wd;
    logic [7:0] e_wdat, e_ldata;
    @(negedge Clk);
    Reset = rst; LdValid = lv; LdAddr = la; LdData = ldd;
    AluValid = av; AluAddr = aa; AluData = ad; LookupAddr = lk;
    #1;
    n  = q.size();
    fr = DEPTH - n;
    e_lr = 1'b0; e_ar = 1'b0; e_wen = 1'b0; e_wd = '0; e_wdat = '0; e_hit = 1'b0; e_ldata = '0;
    if (!rst) begin
      e_lr = (fr >= 1);
      e_ar = lv ? (fr >= 2) : (fr >= 1);
      if (n != 0) begin
        e_wen = 1'b1; e_wd = q[0].a; e_wdat = q[0].d;
      end
`ifdef WB_FWD_EN
      for (int i = n - 1; i >= 0; i--) begin
        if (q[i].a == lk) begin
          e_hit = 1'b1; e_ldata = q[i].d;
          break;
        end
      end
`endif
    end
    check($sformatf("c%0d_lready", cyc), 32'(LdReady), 32'(e_lr));
    check($sformatf("c%0d_aready", cyc), 32'(AluReady), 32'(e_ar));
    check($sformatf("c%0d_wen", cyc), 32'(Wen), 32'(e_wen));
    check($sformatf("c%0d_wd", cyc), 32'(Wd), 32'(e_wd));
    check($sformatf("c%0d_wdat", cyc), 32'(Wdat), 32'(e_wdat));
    check($sformatf("c%0d_level", cyc), 32'(Level), rst ? 32'd0 : 32'(n));
    check($sformatf("c%0d_lhit", cyc), 32'(LookupHit), 32'(e_hit));
    check($sformatf("c%0d_ldata", cyc), 32'(LookupData), 32'(e_ldata));
    obs_wen = Wen; obs_wd = Wd; obs_wdat = Wdat; obs_level = Level;
    obs_lready = LdReady; obs_aready = AluReady; obs_hit = LookupHit; obs_ldata = LookupData;
    if (Wen === 1'b1) dut_rf[Wd] = Wdat;
    @(posedge Clk);
    if (rst) begin
      q.delete();
    end else begin
      if (n != 0) begin
        rf[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (lv && e_lr) q.push_back('{la, ldd});
      if (av && e_ar) q.push_back('{aa, ad});
    end
    cyc++;
  endtask

  task automatic idle(input logic [1:0] lk);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, lk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rf[i] = '0;
      dut_rf[i] = '0;
    end
    Reset = 1'b1; LdValid = 1'b0; LdAddr = '0; LdData = '0;
    AluValid = 1'b0; AluAddr = '0; AluData = '0; LookupAddr = '0;

    // Reset state
    step(1'b1, 1'b1, 2'd1, 8'hAA, 1'b1, 2'd2, 8'hBB, 2'd0);
    check("rst_wen", 32'(obs_wen), 32'd0);
    check("rst_lready", 32'(obs_lready), 32'd0);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);

    // Single load: visible on the write port the cycle after acceptance
    step(1'b0, 1'b1, 2'd1, 8'h5A, 1'b0, 2'd0, 8'h00, 2'd0);
    idle(2'd0);
    check("t1_wen", 32'(obs_wen), 32'd1);
    check("t1_wd", 32'(obs_wd), 32'd1);
    check("t1_wdat", 32'(obs_wdat), 32'h5A);
    idle(2'd0);
    check("t1_idle_wen", 32'(obs_wen), 32'd0);
    check("t1_idle_wdat", 32'(obs_wdat), 32'd0);

    // Dual accept to the same register: load older, ALU younger wins
    step(1'b0, 1'b1, 2'd2, 8'h11, 1'b1, 2'd2, 8'h22, 2'd0);
    idle(2'd0);
    check("t2_first", 32'(obs_wdat), 32'h11);
    idle(2'd0);
    check("t2_second", 32'(obs_wdat), 32'h22);
    idle(2'd0);
    check("t2_rf2", 32'(dut_rf[2]), 32'h22);

    // Continuous dual offers: Level settles at DEPTH-1 where only the load fits
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 2'(i), 8'($urandom), 1'b1, 2'(i + 1), 8'($urandom), 2'd0);
    check("fill_level", 32'(obs_level), 32'd3);
    check("fill_aready_lv", 32'(obs_aready), 32'd0);
    check("fill_lready", 32'(obs_lready), 32'd1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h77, 2'd0);
    check("lvl3_aready_nolv", 32'(obs_aready), 32'd1);
    for (int i = 0; i < 4; i++) idle(2'd0);

    // Reset with Level=3: everything discarded, no writes in or after the reset cycle
    step(1'b0, 1'b1, 2'd0, 8'hC0, 1'b1, 2'd1, 8'hC1, 2'd0);
    step(1'b0, 1'b1, 2'd2, 8'hC2, 1'b1, 2'd3, 8'hC3, 2'd0);
    step(1'b0, 1'b1, 2'd1, 8'hC4, 1'b0, 2'd0, 8'h00, 2'd0);
    check("mid_level", 32'(obs_level), 32'd3);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
    check("mid_rst_wen", 32'(obs_wen), 32'd0);
    idle(2'd0);
    check("post_rst_wen", 32'(obs_wen), 32'd0);
    check("post_rst_level", 32'(obs_level), 32'd0);

    // Forwarding: youngest pending value for address 3
    step(1'b0, 1'b1, 2'd3, 8'h40, 1'b1, 2'd3, 8'h41, 2'd3);
    idle(2'd3);
`ifdef WB_FWD_EN
    check("fwd_hit3", 32'(obs_hit), 32'd1);
    check("fwd_data3", 32'(obs_ldata), 32'h41);
`else
    check("nofwd_hit3", 32'(obs_hit), 32'd0);
    check("nofwd_data3", 32'(obs_ldata), 32'd0);
`endif
    idle(2'd0);
    check("fwd_hit0", 32'(obs_hit), 32'd0);
    idle(2'd0);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom), 8'($urandom),
           1'($urandom), 2'($urandom), 8'($urandom), 2'($urandom));
    for (int i = 0; i < 5; i++) idle(2'd0);

    for (int i = 0; i < 4; i++)
      check($sformatf("rf%0d", i), 32'(dut_rf[i]), 32'(rf[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
